// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs instruction fields into a 32-bit word
// and streams it out with a sequential byte address over valid/ready.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [31:0]      addr,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        accept;
  logic        full_w;
  logic        ok_12;
  logic        ok_13;
  logic        ok_21;

  // Sign-extension checks: the dropped upper bits must all match
  assign ok_12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign ok_13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign ok_21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !ok_12;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3,
                    imm[4:0], opcode};
        enc_err  = !ok_12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                    imm[4:1], imm[11], opcode};
        enc_err  = imm[0] | !ok_13;
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                    rd, opcode};
        enc_err  = imm[0] | !ok_21;
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign full_w = (count_q == CNT_W'(DEPTH));

  // Gated by rst so the handshake reads idle while reset is held
  assign in_ready = !rst && !full_w &&
                    ((state_q == EMPTY) ||
                     ((state_q == HOLD) && out_ready));

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    if (accept) begin
      state_d  = HOLD;
      count_d  = count_q + CNT_W'(1);
      instr_d  = enc_word;
      addr_d   = BASE_ADDR + (32'(count_q) << 2);
      err_d    = enc_err;
      sticky_d = sticky_q | enc_err;
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = full_w ? DONE : EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      instr_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign instr      = instr_q;
  assign addr       = addr_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign count      = count_q;
  assign full       = full_w;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a DEPTH=256 instance for encoding and
// backpressure, and a DEPTH=4 instance for full/DONE and async reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        iv, iv4, ordy, ordy4;
  logic [2:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        in_ready, out_valid, err, err_sticky, full;
  logic [31:0] instr, addr;
  logic [8:0]  count;

  logic        in_ready4, out_valid4, err4, err_sticky4, full4;
  logic [31:0] instr4, addr4;
  logic [2:0]  count4;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(ordy), .instr(instr),
    .addr(addr), .err(err), .err_sticky(err_sticky),
    .count(count), .full(full)
  );

  instr_encoder #(.DEPTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(in_ready4),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid4), .out_ready(ordy4), .instr(instr4),
    .addr(addr4), .err(err4), .err_sticky(err_sticky4),
    .count(count4), .full(full4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_f(input logic [2:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    iv = 1'b0; iv4 = 1'b0; ordy = 1'b1; ordy4 = 1'b1;
    set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", {30'd0, err, err_sticky}, 32'd0);
    chk("rst_full_ready", {30'd0, full, in_ready}, 32'd0);

    // Single addi
    rst = 1'b0;
    iv = 1'b1;
    #1 chk("addi_in_ready", 32'(in_ready), 32'd1);
    step();
    iv = 1'b0;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", instr, 32'h0050_0093);
    chk("addi_addr", addr, 32'd0);
    chk("addi_err", 32'(err), 32'd0);
    chk("addi_count", 32'(count), 32'd1);

    // Back-to-back stream from a fresh reset
    rst = 1'b1;
    #1 rst = 1'b0;
    set_f(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    iv = 1'b1;
    #1 chk("r_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("r_instr", instr, 32'h0020_81B3);
    chk("r_addr", addr, 32'd0);
    set_f(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    #1 chk("s_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("s_instr", instr, 32'h0020_A423);
    chk("s_addr", addr, 32'd4);
    set_f(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    #1 chk("b_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("b_instr", instr, 32'hFE20_8EE3);
    chk("b_addr", addr, 32'd8);
    chk("b_err", 32'(err), 32'd0);
    set_f(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    chk("u_instr", instr, 32'h1234_52B7);
    chk("u_addr", addr, 32'd12);
    set_f(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    chk("j_instr", instr, 32'h0080_00EF);
    chk("j_err", {30'd0, err, err_sticky}, 32'd0);
    set_f(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    step();
    chk("jodd_instr", instr, 32'h0060_00EF);
    chk("jodd_err", {30'd0, err, err_sticky}, 32'd3);
    chk("jodd_addr", addr, 32'd20);
    set_f(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
    step();
    chk("ill_instr", instr, 32'h0000_0013);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_addr", addr, 32'd24);
    chk("ill_count", 32'(count), 32'd7);

    // Backpressure with the illegal word held
    set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    ordy = 1'b0;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", instr, 32'h0000_0013);
      chk("bp_addr", addr, 32'd24);
      chk("bp_count", 32'(count), 32'd7);
      chk("bp_hold", {30'd0, out_valid, in_ready}, 32'd2);
    end
    ordy = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);
    step();
    iv = 1'b0;
    chk("rel_instr", instr, 32'h0050_0093);
    chk("rel_addr", addr, 32'd28);
    chk("rel_count", 32'(count), 32'd8);
    chk("rel_err", {30'd0, err, err_sticky}, 32'd1);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // DEPTH=4 instance: fill, then DONE
    rst4 = 1'b0;
    iv4 = 1'b1;
    #1 chk("d4_in_ready", 32'(in_ready4), 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("d4_count", 32'(count4), 32'd4);
    chk("d4_full", 32'(full4), 32'd1);
    chk("d4_in_ready_full", 32'(in_ready4), 32'd0);
    chk("d4_addr", addr4, 32'd12);
    step();
    chk("d4_done_valid", 32'(out_valid4), 32'd0);
    chk("d4_done_count", 32'(count4), 32'd4);
    step();
    chk("d4_ignored", {28'd0, count4, in_ready4}, {28'd0, 3'd4, 1'b0});

    // Async reset while a word is held
    rst4 = 1'b1;
    #1 rst4 = 1'b0;
    set_f(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    ordy4 = 1'b0;
    step();
    iv4 = 1'b0;
    chk("d4_held", {30'd0, out_valid4, err_sticky4}, 32'd3);
    #2 rst4 = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid4), 32'd0);
    chk("ar_instr", instr4, 32'd0);
    chk("ar_addr", addr4, 32'd0);
    chk("ar_count", 32'(count4), 32'd0);
    chk("ar_flags", {28'd0, err4, err_sticky4, full4, in_ready4}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Field-to-word encoder for RV32I. It is the inverse of the core's decode stage.
- Accepts instruction fields (format, opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake.
- Packs them into a 32-bit instruction word and presents it with a sequential word address over a second valid/ready handshake.
- Used by the program loader and the test harness to fill instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted instruction.
- DEPTH, 256, maximum number of instructions accepted before the block reports full.
- CNT_W, 9, count width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept a field set
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R only)
- imm  in  32  immediate as full signed byte value; U takes the final upper value
- out_valid  out  1  instr/addr valid
- out_ready  in  1  consumer takes word
- instr  out  32  encoded instruction
- addr  out  32  byte address of instr
- err  out  1  qualifies the current output beat: immediate out of range or illegal fmt
- err_sticky  out  1  OR of all err beats since reset
- count  out  CNT_W  number of instructions accepted
- full  out  1  count == DEPTH

Behaviour:
- Reset (async, any state): all outputs go to 0 and state goes to EMPTY. instr resets to 0, not to a NOP.
- States:
  - EMPTY: no word held.
  - HOLD: word held, out_valid=1.
  - DONE: DEPTH accepted and last word drained.
- Accept condition: in_valid && in_ready.
- in_ready = !full && (state==EMPTY || (state==HOLD && out_ready)). This is combinational and allows one word per cycle back to back.
- On accept:
  - instr, err and addr are registered; output appears the next cycle (latency 1).
  - addr = BASE_ADDR + 4*count, where count is its pre-increment value.
  - count increments and the state goes to HOLD.
- Transitions:
  - HOLD with out_ready and no accept → EMPTY, or → DONE if full.
  - HOLD with out_ready and accept at the same time → stays HOLD with the new word.
  - HOLD with !out_ready: instr, addr and err stay stable; in_ready=0.
- full asserts the cycle after the DEPTH-th accept. After that in_ready stays 0 until reset; in_valid is ignored.
- Encoding (bit concatenation, MSB first):
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
- Unused fields are ignored; e.g. rs2/funct7 are don't-care for I.
- Range checks set err on that beat. The word is still encoded from the truncated bits.
  - I, S: imm[31:11] is not all-equal.
  - B: imm[0]!=0, or imm[31:12] is not all-equal.
  - J: imm[0]!=0, or imm[31:20] is not all-equal.
  - U: imm[11:0]!=0.
  - R: never errors.
- Illegal fmt (6, 7): instr=32'h0000_0013 (NOP) and err=1. The beat still consumes an address and a count.
- err_sticky sets on any accepted err beat, in the same cycle err is registered. It is cleared only by reset.
- Reset asserted mid-HOLD discards the held word; no output handshake occurs.

Test Plan:
- After reset, send I addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 → next cycle out_valid=1, instr=0x00500093, addr=0, err=0, count=1.
- Back-to-back with out_ready=1:
  - R add x3,x1,x2 (opcode 0110011) → 0x002081B3 at addr 0.
  - S sw x2,8(x1) (opcode 0100011, funct3=2) → 0x0020A423 at addr 4.
  - B beq x1,x2,-4 (opcode 1100011) → 0xFE208EE3 at addr 8.
  - in_ready stays 1 throughout; no bubbles.
- U lui x5 with imm=0x12345000 (opcode 0110111) → 0x123452B7. J jal x1,+8 (opcode 1101111) → 0x008000EF. Then J with imm=7 → err=1 and err_sticky=1 on that beat.
- Backpressure: hold out_ready=0 for 5 cycles with a word held → instr/addr stable, in_ready=0, count unchanged. Release → handshake completes, then the next accept proceeds.
- DEPTH=4 build: accept 4 words → full=1, in_ready=0. A 5th in_valid is ignored; count stays 4 and the state reaches DONE. Assert rst mid-stream → all outputs return to 0 immediately, without waiting for a clock edge.
- fmt=7 → instr=0x00000013, err=1, addr advances by 4.
